// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch: digit type, digit limits,
// and the clamp used when a preset is loaded.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIG_MAX9 = 4'd9;
    localparam bcd_t DIG_MAX5 = 4'd5;

    function automatic bcd_t clamp_digit(bcd_t d, bcd_t d_max);
        return (d > d_max) ? d_max : d;
    endfunction

    // Only the tens-of-seconds digit is base 6; every other digit is decimal.
    function automatic bcd_t digit_max(int idx);
        return (idx == 3) ? DIG_MAX5 : DIG_MAX9;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with load-with-clamp and up/down count; carry and borrow
// flag the next digit in the chain.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = DIG_MAX9
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_down,
    input  logic       i_load,
    input  logic [3:0] i_load_d,
    output logic [3:0] o_q,
    output logic       o_carry_out,
    output logic       o_borrow_out
);

    bcd_t r_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= clamp_digit(i_load_d, MAX);
        end else if (i_en) begin
            if (i_down) begin
                r_q <= (r_q == '0) ? MAX : r_q - 4'd1;
            end else begin
                r_q <= (r_q == MAX) ? '0 : r_q + 4'd1;
            end
        end
    end

    assign o_q          = r_q;
    assign o_carry_out  = !i_down && (r_q == MAX);
    assign o_borrow_out = i_down && (r_q == '0);

endmodule

// File: rtl/stopwatch_lap.sv
// BCD stopwatch/timer: prescaled centisecond tick, up/down digit chain,
// sticky countdown DONE, rollover WRAP pulse and lap capture register.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int MIN_DIGITS = 1,
    localparam int TW        = 16 + 4 * MIN_DIGITS
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_enable,
    input  logic          i_down,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_lap,
    output logic [TW-1:0] o_time,
    output logic [TW-1:0] o_lap_time,
    output logic          o_lap_valid,
    output logic          o_done,
    output logic          o_wrap
);

    localparam int ND = 4 + MIN_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] r_pcnt;
    logic [TW-1:0] r_lap_time;
    logic          r_lap_valid;
    logic          r_done;
    logic          r_wrap;

    logic          w_time_zero;
    logic          w_inhibit;
    logic          w_pcnt_last;
    logic          w_tick;
    logic          w_done_set;
    logic [ND:0]   w_en_chain;
    logic [ND-1:0] w_carry;
    logic [ND-1:0] w_borrow;

    assign w_time_zero = (o_time == '0);
    assign w_inhibit   = i_down && w_time_zero;
    assign w_pcnt_last = (r_pcnt == PW'(TICK_DIV - 1));
    // Gating with load keeps WRAP/DONE quiet when a preset wins the edge.
    assign w_tick      = i_enable && w_pcnt_last && !w_inhibit && !i_load;
    assign w_done_set  = w_tick && i_down && (o_time == TW'(1));

    assign w_en_chain[0] = w_tick;

    for (genvar g = 0; g < ND; g++) begin : g_digit
        bcd_digit_counter #(
            .MAX (digit_max(g))
        ) u_digit (
            .i_clk        (i_clk),
            .i_reset_n    (i_reset_n),
            .i_en         (w_en_chain[g]),
            .i_down       (i_down),
            .i_load       (i_load),
            .i_load_d     (i_load_val[4*g +: 4]),
            .o_q          (o_time[4*g +: 4]),
            .o_carry_out  (w_carry[g]),
            .o_borrow_out (w_borrow[g])
        );
        assign w_en_chain[g+1] = w_en_chain[g] && (w_carry[g] || w_borrow[g]);
    end

    // Prescaler freezes (not clears) when paused or inhibited.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pcnt <= '0;
        end else if (i_load) begin
            r_pcnt <= '0;
        end else if (i_enable && !w_inhibit) begin
            r_pcnt <= w_pcnt_last ? '0 : r_pcnt + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_en_chain[ND] && !i_down;
            if (i_load) begin
                r_done <= 1'b0;
            end else if (w_done_set) begin
                r_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_lap_time  <= '0;
            r_lap_valid <= 1'b0;
        end else if (i_lap) begin
            r_lap_time  <= o_time;
            r_lap_valid <= 1'b1;
        end
    end

    assign o_lap_time  = r_lap_time;
    assign o_lap_valid = r_lap_valid;
    assign o_done      = r_done;
    assign o_wrap      = r_wrap;

endmodule

// File: doc/stopwatch_lap.md
# stopwatch_lap

Parametrised BCD stopwatch/timer that succeeds the fixed single-minute-digit up-counting stopwatch. It adds a clock prescaler, configurable minute-digit count, a countdown mode with preset load and done flag, and a lap-capture register. It sits between the board clock/button synchronisers and the seven-segment display mux, which reads `TIME` or `LAP_TIME`.

## Interface
- `TICK_DIV`, 1, CLK cycles per centisecond tick; legal range ≥1. 1 gives one tick per enabled cycle.
- `MIN_DIGITS`, 1, number of BCD minute digits; legal range 1–2.
- `TW`, 16+4*MIN_DIGITS, derived time-vector width; not overridable.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET_N` in 1: reset, synchronous, active-low.
- `ENABLE` in 1: run when high, hold when low.
- `DOWN` in 1: 0 selects count up, 1 selects count down.
- `LOAD` in 1: load `LOAD_VAL` into the time.
- `LOAD_VAL` in TW: BCD preset, same layout as `TIME`.
- `LAP` in 1: capture the current time into `LAP_TIME`.
- `TIME` out TW: packed BCD time. Layout from MSB: {min digits, tensec, sec, decisec, centisec}, 4 bits per digit.
- `LAP_TIME` out TW: last captured time.
- `LAP_VALID` out 1: a lap has been captured since reset.
- `DONE` out 1: sticky flag; countdown reached zero.
- `WRAP` out 1: one-cycle pulse when the up-count rolls over from its maximum.

## Operation
- Digit ranges: centisec, decisec, sec 0–9; tensec 0–5; each minute digit 0–9. Maximum time is 9:59.99 (MIN_DIGITS=1) or 99:59.99 (MIN_DIGITS=2).
- Prescaler `pcnt`, 0..TICK_DIV-1, advances only when ENABLE=1 and counting is not inhibited. `tick` = ENABLE & (pcnt==TICK_DIV-1) & !inhibit. On tick, pcnt returns to 0.
- Up count: the tick increments centisec. Each digit carries into the next digit when it passes its max. At the maximum, all digits go to 0 and WRAP pulses for 1 cycle.
- Down count: the tick decrements with borrow. Digit 0 borrows and reloads to its max (9 or 5).
  - On the tick that reaches all-zero, DONE is set.
  - While DOWN=1 and TIME==0, inhibit=1: no decrement, no wrap, pcnt is frozen.
- DOWN may change at any time. It takes effect on the next tick, and pcnt is not cleared.
- LOAD: TIME ← LOAD_VAL with per-digit clamp (any digit above its max becomes its max). Also pcnt←0 and DONE←0. LOAD overrides the tick in the same cycle.
- LAP: LAP_TIME ← TIME as registered before the edge, i.e. the value visible in the LAP cycle. Sets LAP_VALID=1. LAP together with LOAD captures the pre-load value.
- Priority: RESET_N low > LOAD > tick > hold.
- Reset (RESET_N=0 at an edge): TIME=0, LAP_TIME=0, LAP_VALID=0, DONE=0, WRAP=0, pcnt=0. Reset overrides ENABLE, LOAD and LAP, including in the middle of a count.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- With TICK_DIV=1: ENABLE=1 sampled at edge k → TIME shows +1 centisec after edge k.
- With TICK_DIV=N: the first increment appears N enabled edges after reset or LOAD.
- LOAD, LAP and DONE take effect at the sampling edge (1-cycle latency). WRAP is high exactly during the cycle after the rollover edge.
- Pausing (ENABLE=0) freezes pcnt mid-count. Resuming continues from the frozen pcnt with no lost partial period.

## Structure
- Package `stopwatch_pkg`:
  - `bcd_t` (logic [3:0])
  - constants `DIG_MAX9`=9, `DIG_MAX5`=5
  - function `clamp_digit(bcd_t d, bcd_t max)`
- Sub-module `bcd_digit_counter`, parameter MAX:
  - inputs: en, down, load, load_d
  - outputs: q, carry_out (at max going up), borrow_out (at 0 going down)
  - instantiated 4+MIN_DIGITS times, chained via carry/borrow into the next digit's en.
- Top level holds the prescaler, the DONE/WRAP/inhibit logic and the lap register.

## Test plan
- TICK_DIV=1, MIN_DIGITS=1: reset, then ENABLE=1 for 200 cycles → TIME=0x00200 after 200 edges; every intermediate value matches the BCD sequence.
- LOAD_VAL=0x95997, up, 3 ticks → 0x95998, 0x95999, 0x00000 with WRAP=1 for one cycle; then 0x00001.
- DOWN=1, LOAD 0x00003, 5 enabled cycles → 0x00002, 0x00001, 0x00000, DONE=1. TIME holds 0x00000 afterwards. LOAD 0x10000 clears DONE, and the next tick gives 0x05999.
- TICK_DIV=4: ENABLE high 2 cycles, low 5, high 2 → first increment after the 4th enabled edge; TIME=0x00001; no change while ENABLE is low.
- LAP at TIME=0x01234 together with LOAD 0x00000 → LAP_TIME=0x01234, LAP_VALID=1, TIME=0x00000. LOAD_VAL=0xA7BCF → TIME clamps to 0x95999.
- RESET_N=0 in the middle of a count with ENABLE=1, DOWN=1, LAP=1 → every output is 0 after one edge. Holding reset low 5 cycles keeps all outputs 0.
